// File: rtl/fast_serial_rx.sv
`default_nettype none
// ============================================================================
// Module   : fast_serial_rx
// Purpose  : 8N1 asynchronous deserializer feeding a show-ahead byte FIFO with
//            sticky frame/overrun/parity error flags.
// Options  : define FAST_SERIAL_RX_PARITY_EN for an even-parity bit (8E1).
// Revision : 1.0 - initial release
// ============================================================================
module fast_serial_rx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                          CLK0,
    input  logic                          reset_crg,
    input  logic                          rx_in,
    output logic [7:0]                    m_data,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          frame_err,
    output logic                          overrun,
    output logic                          parity_err,
    input  logic                          err_clr
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] c_half_m1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] c_full_m1 = CW'(CLKS_PER_BIT - 1);
    localparam logic [AW:0]   c_depth   = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4,
        S_BREAK  = 3'd5
    } state_t;

    logic          r_rx_meta, r_rx_s, r_rx_prev;
    logic          w_fall;
    state_t        r_state, w_state_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic [2:0]    r_bit, w_bit_nxt;
    logic [7:0]    r_shift, w_shift_nxt;
    logic          w_tick, w_push, w_set_frame, w_set_par;
    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr, r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_pop, w_full, w_wr, w_ovf;
`ifdef FAST_SERIAL_RX_PARITY_EN
    logic          r_par_bad, w_par_bad_nxt;
`endif

    // Two-flop synchronizer plus one history flop for falling-edge detection
    always_ff @(posedge CLK0) begin
        if (reset_crg) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_meta <= rx_in;
            r_rx_s    <= r_rx_meta;
            r_rx_prev <= r_rx_s;
        end
    end

    assign w_fall = r_rx_prev & ~r_rx_s;
    assign w_tick = (r_cnt == '0);

    always_ff @(posedge CLK0) begin
        if (reset_crg) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
`ifdef FAST_SERIAL_RX_PARITY_EN
            r_par_bad <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_bit   <= w_bit_nxt;
            r_shift <= w_shift_nxt;
`ifdef FAST_SERIAL_RX_PARITY_EN
            r_par_bad <= w_par_bad_nxt;
`endif
        end
    end

    // Counter is loaded with half a bit on the start edge so every later
    // sample lands mid-bit after whole-bit reloads.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        w_push      = 1'b0;
        w_set_frame = 1'b0;
        w_set_par   = 1'b0;
`ifdef FAST_SERIAL_RX_PARITY_EN
        w_par_bad_nxt = r_par_bad;
`endif
        case (r_state)
            S_IDLE: begin
                if (w_fall) begin
                    w_state_nxt = S_START;
                    w_cnt_nxt   = c_half_m1;
                    w_bit_nxt   = '0;
`ifdef FAST_SERIAL_RX_PARITY_EN
                    w_par_bad_nxt = 1'b0;
`endif
                end
            end
            S_START: begin
                if (w_tick) begin
                    w_cnt_nxt   = c_full_m1;
                    w_state_nxt = r_rx_s ? S_IDLE : S_DATA;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            S_DATA: begin
                if (w_tick) begin
                    w_cnt_nxt   = c_full_m1;
                    w_shift_nxt = {r_rx_s, r_shift[7:1]};
                    w_bit_nxt   = r_bit + 1'b1;
                    if (r_bit == 3'd7) begin
`ifdef FAST_SERIAL_RX_PARITY_EN
                        w_state_nxt = S_PARITY;
`else
                        w_state_nxt = S_STOP;
`endif
                    end
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
`ifdef FAST_SERIAL_RX_PARITY_EN
            S_PARITY: begin
                if (w_tick) begin
                    w_cnt_nxt   = c_full_m1;
                    w_state_nxt = S_STOP;
                    if (r_rx_s != ^r_shift) begin
                        w_set_par     = 1'b1;
                        w_par_bad_nxt = 1'b1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
`endif
            S_STOP: begin
                if (w_tick) begin
                    if (r_rx_s) begin
`ifdef FAST_SERIAL_RX_PARITY_EN
                        w_push = ~r_par_bad;
`else
                        w_push = 1'b1;
`endif
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_set_frame = 1'b1;
                        w_state_nxt = S_BREAK;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            S_BREAK: begin
                if (r_rx_s) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // A pop at full frees the slot the simultaneous push needs
    assign w_full = (r_count == c_depth);
    assign w_pop  = m_valid & m_ready;
    assign w_wr   = w_push & (~w_full | w_pop);
    assign w_ovf  = w_push & w_full & ~w_pop;

    always_ff @(posedge CLK0) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= r_shift;
        end
    end

    always_ff @(posedge CLK0) begin
        if (reset_crg) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            frame_err <= w_set_frame | (frame_err & ~err_clr);
            overrun   <= w_ovf | (overrun & ~err_clr);
        end
    end

`ifdef FAST_SERIAL_RX_PARITY_EN
    always_ff @(posedge CLK0) begin
        if (reset_crg) begin
            parity_err <= 1'b0;
        end else begin
            parity_err <= w_set_par | (parity_err & ~err_clr);
        end
    end
`else
    assign parity_err = 1'b0;
`endif

    assign m_valid = (r_count != '0);
    assign m_data  = r_mem[r_rd_ptr];
    assign level   = r_count;

endmodule
`default_nettype wire

// File: tb/tb_fast_serial_rx.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_fast_serial_rx
// Purpose  : Scoreboard bench for fast_serial_rx; bytes expected on the stream
//            are queued at send time and compared when popped.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fast_serial_rx;
    localparam int CPB   = 16;
    localparam int DEPTH = 16;
    localparam int LW    = $clog2(DEPTH) + 1;
`ifdef FAST_SERIAL_RX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    // Send-start edge to stop-sample edge: 3 cycles of sync/edge detect,
    // half a bit to mid-start, then one bit per remaining frame bit.
    localparam int STOP_EDGE = 3 + CPB / 2 + CPB * (NBITS - 1);

    logic          clk, rst, rx_in, m_ready, err_clr;
    logic [7:0]    m_data;
    logic          m_valid, frame_err, overrun, parity_err;
    logic [LW-1:0] level;

    int         n_checks = 0;
    int         n_pass   = 0;
    logic [7:0] exp_q[$];
    logic [7:0] mon_exp;

    fast_serial_rx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .CLK0       (clk),
        .reset_crg  (rst),
        .rx_in      (rx_in),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .level      (level),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .parity_err (parity_err),
        .err_clr    (err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    endtask

    // Scoreboard side: every accepted pop must match the oldest queued byte
    always @(negedge clk) begin
        if (!rst && m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected", {24'd0, m_data}, 32'hFFFF_FFFF);
            end else begin
                mon_exp = exp_q.pop_front();
                check("sb_data", {24'd0, m_data}, {24'd0, mon_exp});
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_bit(input logic b);
        rx_in = b;
        tick(CPB);
    endtask

    // Line is left at the stop-bit value so a low stop can run into a break
    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop,
                              input bit expect_push);
        if (expect_push) exp_q.push_back(d);
        @(posedge clk);
        #1;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef FAST_SERIAL_RX_PARITY_EN
        drive_bit(par);
`else
        if (par === 1'bx) rx_in = 1'b1;
`endif
        drive_bit(stop);
    endtask

    task automatic send_good(input logic [7:0] d);
        send_frame(d, ^d, 1'b1, 1'b1);
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
    endtask

    task automatic drain();
        int guard;
        guard   = 0;
        m_ready = 1'b1;
        while (m_valid && guard < 4 * DEPTH) begin
            tick(1);
            guard++;
        end
        m_ready = 1'b0;
        tick(1);
        check("drain_empty", m_valid, 1'b0);
        check("sb_empty", exp_q.size(), 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b;
        rst = 1'b1; rx_in = 1'b1; m_ready = 1'b0; err_clr = 1'b0;
        tick(5);
        rst = 1'b0;
        tick(2);
        check("rst_valid", m_valid, 1'b0);
        check("rst_level", level, 0);
        check("rst_ferr", frame_err, 1'b0);
        check("rst_ovr", overrun, 1'b0);
        check("rst_perr", parity_err, 1'b0);

        // Single byte, exact push latency
        fork
            send_good(8'hA5);
            begin
                @(posedge clk);
                #1;
                tick(STOP_EDGE - 1);
                check("t1_valid_early", m_valid, 1'b0);
                tick(1);
                check("t1_valid", m_valid, 1'b1);
                check("t1_data", m_data, 8'hA5);
                check("t1_level", level, 1);
            end
        join
        drain();

        // Glitch shorter than half a bit
        rx_in = 1'b0;
        tick(6);
        rx_in = 1'b1;
        tick(3 * CPB);
        check("t2_level", level, 0);
        check("t2_ferr", frame_err, 1'b0);
        check("t2_perr", parity_err, 1'b0);

        // Overflow: 17 bytes into a 16-entry FIFO, last one lost
        for (int i = 0; i <= DEPTH; i++) begin
            b = 8'(i);
            send_frame(b, ^b, 1'b1, i < DEPTH);
        end
        tick(2);
        check("t3_level", level, DEPTH);
        check("t3_ovr", overrun, 1'b1);
        check("t3_head", m_data, 8'h00);
        pulse_clr();
        check("t3_ovr_clr", overrun, 1'b0);

        // Push coincident with a pop at full
        fork
            send_good(8'h77);
            begin
                @(posedge clk);
                #1;
                tick(STOP_EDGE - 1);
                m_ready = 1'b1;
                tick(1);
                m_ready = 1'b0;
            end
        join
        check("t5_level", level, DEPTH);
        check("t5_ovr", overrun, 1'b0);
        pulse_clr();
        check("t5_clr_ferr", frame_err, 1'b0);
        check("t5_clr_ovr", overrun, 1'b0);
        check("t5_clr_perr", parity_err, 1'b0);
        drain();

        // Framing error followed by a long break: one flag, no pushes
        send_frame(8'h3C, ^8'h3C, 1'b0, 1'b0);
        check("t4_ferr", frame_err, 1'b1);
        check("t4_level_bad", level, 0);
        pulse_clr();
        tick(40 * CPB);
        check("t4_ferr_once", frame_err, 1'b0);
        check("t4_level_brk", level, 0);
        rx_in = 1'b1;
        tick(2 * CPB);
        send_good(8'h5A);
        tick(2);
        check("t4_level_good", level, 1);
        check("t4_ferr_after", frame_err, 1'b0);
        drain();

`ifdef FAST_SERIAL_RX_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b1, 1'b1);
        tick(2);
        check("t6_level_ok", level, 1);
        check("t6_perr_ok", parity_err, 1'b0);
        send_frame(8'h07, 1'b0, 1'b1, 1'b0);
        tick(2);
        check("t6_perr", parity_err, 1'b1);
        check("t6_level_bad", level, 1);
        check("t6_ferr", frame_err, 1'b0);
        drain();
        pulse_clr();
        check("t6_perr_clr", parity_err, 1'b0);
`endif

        // Reset in the middle of data bit 4 with state to discard
        send_good(8'h42);
        send_frame(8'hE7, ^8'hE7, 1'b0, 1'b0);
        rx_in = 1'b1;
        tick(2 * CPB);
        check("t7_pre_level", level, 1);
        check("t7_pre_ferr", frame_err, 1'b1);
        b = 8'h99;
        @(posedge clk);
        #1;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(b[i]);
        rx_in = b[4];
        tick(CPB / 2);
        rst = 1'b1;
        exp_q.delete();
        rx_in = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(1);
        check("t7_level", level, 0);
        check("t7_valid", m_valid, 1'b0);
        check("t7_ferr", frame_err, 1'b0);
        check("t7_ovr", overrun, 1'b0);
        check("t7_perr", parity_err, 1'b0);
        tick(2 * CPB);
        send_good(8'h81);
        tick(2);
        check("t7_level_new", level, 1);
        check("t7_data_new", m_data, 8'h81);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
